// File: rtl/pisca_pkg.sv
// Shared definitions for the acertos blink responder: FSM encodings, debug codes
// and the counter-width helper used by the top and its cycle counters.
package pisca_pkg;

  typedef enum logic [1:0] {
    OCIOSO   = 2'b00,
    ACESO    = 2'b01,
    APAGADO  = 2'b10,
    INVALIDO = 2'b11
  } estadoT;

  localparam logic [1:0] DB_OCIOSO  = 2'b00;
  localparam logic [1:0] DB_ACESO   = 2'b01;
  localparam logic [1:0] DB_APAGADO = 2'b10;

  // A terminal count of 1 still needs one bit so the counter has a real register.
  function automatic int larguraContador(input int t);
    return $clog2((t < 2) ? 2 : t);
  endfunction

  function automatic logic [1:0] dbCodigo(input estadoT e);
    case (e)
      ACESO:   return DB_ACESO;
      APAGADO: return DB_APAGADO;
      default: return DB_OCIOSO;
    endcase
  endfunction

endpackage

// File: rtl/contador_fim.sv
// Phase timer: counts while enable is high, clears whenever enable drops,
// saturates at T-1 and flags the last cycle combinationally on fim.
module contador_fim
  import pisca_pkg::*;
#(
  parameter int T = 500
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic fim
);

  localparam int W = larguraContador(T);
  localparam logic [W-1:0] ULTIMO = W'(T - 1);

  logic [W-1:0] contagemReg;

  always_ff @(posedge clock) begin
    if (reset || !enable) begin
      contagemReg <= '0;
    end else if (contagemReg != ULTIMO) begin
      contagemReg <= contagemReg + 1'b1;
    end
  end

  assign fim = enable && (contagemReg == ULTIMO);

endmodule

// File: rtl/pisca_acertos_resp.sv
// Responder for the acertos LED-blink handshake: times on/off phases, counts blinks
// and drives the LEDs. Define PISCA_CHECK_EN to add the sticky erro_protocolo output.
module pisca_acertos_resp
  import pisca_pkg::*;
#(
  parameter int N_LEDS     = 4,
  parameter int T_ON       = 500,
  parameter int T_OFF      = 500,
  parameter int N_PISCADAS = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              contaLedsOn,
  input  logic              contaLedsOff,
  input  logic              contaPiscadas,
  input  logic              apagarAcertos,
  input  logic [N_LEDS-1:0] acertos,
  output logic              fimLedsOn,
  output logic              fimLedsOff,
  output logic              fimPiscaLeds,
  output logic [N_LEDS-1:0] leds,
  output logic [1:0]        db_estado
`ifdef PISCA_CHECK_EN
  ,
  output logic              erro_protocolo
`endif
);

  localparam int WP = larguraContador(N_PISCADAS + 1);
  localparam logic [WP-1:0] PISCADAS_MAX = WP'(N_PISCADAS);

  estadoT          estadoReg;
  estadoT          estadoNext;
  logic [WP-1:0]   piscadasReg;
  logic            piscaPrevReg;
  logic            offEnable;

  // An on strobe wins over a simultaneous off strobe; the off timer stays cleared.
  assign offEnable = contaLedsOff && !contaLedsOn;

  contador_fim #(.T(T_ON)) uContadorOn (
    .clock  (clock),
    .reset  (reset),
    .enable (contaLedsOn),
    .fim    (fimLedsOn)
  );

  contador_fim #(.T(T_OFF)) uContadorOff (
    .clock  (clock),
    .reset  (reset),
    .enable (offEnable),
    .fim    (fimLedsOff)
  );

  assign fimPiscaLeds = (piscadasReg == PISCADAS_MAX);

  always_comb begin
    estadoNext = estadoReg;
    case (estadoReg)
      OCIOSO: begin
        if (contaLedsOn) estadoNext = ACESO;
      end
      ACESO: begin
        if (fimLedsOn && fimPiscaLeds)       estadoNext = OCIOSO;
        else if (contaLedsOff)               estadoNext = APAGADO;
        else if (!contaLedsOn)               estadoNext = OCIOSO;
      end
      APAGADO: begin
        if (contaLedsOn)                     estadoNext = ACESO;
        else if (!contaLedsOff)              estadoNext = OCIOSO;
      end
      default: estadoNext = OCIOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estadoReg    <= OCIOSO;
      db_estado    <= DB_OCIOSO;
      piscadasReg  <= '0;
      piscaPrevReg <= 1'b0;
      leds         <= '0;
    end else begin
      estadoReg    <= estadoNext;
      db_estado    <= dbCodigo(estadoNext);
      piscaPrevReg <= contaPiscadas;
      // One blink per off phase: count only the rising edge of the strobe.
      if (estadoNext == OCIOSO) begin
        piscadasReg <= '0;
      end else if (contaPiscadas && !piscaPrevReg && (piscadasReg != PISCADAS_MAX)) begin
        piscadasReg <= piscadasReg + 1'b1;
      end
      leds <= apagarAcertos ? '0 : acertos;
    end
  end

`ifdef PISCA_CHECK_EN
  logic fimFinalPrevReg;
  logic violacao;

  // Last clause catches the control unit extending the on phase past the final fim.
  assign violacao = (contaLedsOn && contaLedsOff)
                 || (contaPiscadas != contaLedsOff)
                 || (contaLedsOn && fimFinalPrevReg);

  always_ff @(posedge clock) begin
    if (reset) begin
      erro_protocolo  <= 1'b0;
      fimFinalPrevReg <= 1'b0;
    end else begin
      fimFinalPrevReg <= fimLedsOn && fimPiscaLeds && (estadoReg == ACESO);
      if (violacao) erro_protocolo <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pisca_acertos_resp.sv
// Directed self-checking bench for pisca_acertos_resp with T_ON=3, T_OFF=2, N_PISCADAS=2.
module tb_pisca_acertos_resp;

  localparam int N_LEDS     = 4;
  localparam int T_ON       = 3;
  localparam int T_OFF      = 2;
  localparam int N_PISCADAS = 2;

  // Burst timeline, bit i = cycle i
  localparam logic [13:0] ON_V     = 14'b01110011100111;
  localparam logic [13:0] OFF_V    = 14'b00001100011000;
  localparam logic [13:0] FIMON_V  = 14'b01000010000100;
  localparam logic [13:0] FIMOFF_V = 14'b00001000010000;
  int estadoE [14] = '{0, 1, 1, 1, 2, 2, 1, 1, 1, 2, 2, 1, 1, 0};
  int piscaE  [14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, -1, 1, 1, 1, 0};

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              contaLedsOn = 1'b0;
  logic              contaLedsOff = 1'b0;
  logic              contaPiscadas = 1'b0;
  logic              apagarAcertos = 1'b0;
  logic [N_LEDS-1:0] acertos = 4'b1010;
  logic              fimLedsOn;
  logic              fimLedsOff;
  logic              fimPiscaLeds;
  logic [N_LEDS-1:0] leds;
  logic [1:0]        db_estado;
`ifdef PISCA_CHECK_EN
  logic              erro_protocolo;
`endif

  int checks = 0;
  int failures = 0;
  int ciclo = 0;

  always #5 clock = ~clock;

  pisca_acertos_resp #(
    .N_LEDS(N_LEDS), .T_ON(T_ON), .T_OFF(T_OFF), .N_PISCADAS(N_PISCADAS)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .contaLedsOn   (contaLedsOn),
    .contaLedsOff  (contaLedsOff),
    .contaPiscadas (contaPiscadas),
    .apagarAcertos (apagarAcertos),
    .acertos       (acertos),
    .fimLedsOn     (fimLedsOn),
    .fimLedsOff    (fimLedsOff),
    .fimPiscaLeds  (fimPiscaLeds),
    .leds          (leds),
    .db_estado     (db_estado)
`ifdef PISCA_CHECK_EN
    ,
    .erro_protocolo(erro_protocolo)
`endif
  );

  // Drive one cycle's inputs just after the edge and return at the following negedge.
  task automatic tick(input logic rst, input logic on, input logic off,
                      input logic pisc, input logic apag);
    @(posedge clock);
    #1;
    reset = rst; contaLedsOn = on; contaLedsOff = off;
    contaPiscadas = pisc; apagarAcertos = apag;
    @(negedge clock);
    ciclo++;
    $display("cyc %0d rst=%b on=%b off=%b pisc=%b apag=%b | fimOn=%b fimOff=%b fimPisca=%b leds=%b est=%b",
             ciclo, rst, on, off, pisc, apag, fimLedsOn, fimLedsOff, fimPiscaLeds, leds, db_estado);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (db_estado !== 2'b00) begin failures++; $display("FAIL reset_estado got=%b exp=00", db_estado); end
    checks++; if (leds !== 4'b0000) begin failures++; $display("FAIL reset_leds got=%b exp=0000", leds); end
    checks++; if (fimPiscaLeds !== 1'b0) begin failures++; $display("FAIL reset_fimPisca got=%b exp=0", fimPiscaLeds); end
    checks++; if ({fimLedsOn, fimLedsOff} !== 2'b00) begin failures++; $display("FAIL reset_fim got=%b exp=00", {fimLedsOn, fimLedsOff}); end
    idle(1);
  endtask

  task automatic test_burst;
    for (int i = 0; i < 14; i++) begin
      tick(1'b0, ON_V[i], OFF_V[i], OFF_V[i], 1'b0);
      checks++; if (fimLedsOn !== FIMON_V[i]) begin failures++; $display("FAIL burst_fimOn c%0d got=%b exp=%b", i, fimLedsOn, FIMON_V[i]); end
      checks++; if (fimLedsOff !== FIMOFF_V[i]) begin failures++; $display("FAIL burst_fimOff c%0d got=%b exp=%b", i, fimLedsOff, FIMOFF_V[i]); end
      checks++; if (db_estado !== 2'(estadoE[i])) begin failures++; $display("FAIL burst_estado c%0d got=%b exp=%0d", i, db_estado, estadoE[i]); end
      if (piscaE[i] >= 0) begin
        checks++; if (fimPiscaLeds !== 1'(piscaE[i])) begin failures++; $display("FAIL burst_fimPisca c%0d got=%b exp=%0d", i, fimPiscaLeds, piscaE[i]); end
      end
    end
    idle(1);
  endtask

  task automatic test_piscadas_hold;
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (fimPiscaLeds !== 1'b0) begin failures++; $display("FAIL hold_one_phase got=%b exp=0", fimPiscaLeds); end
    for (int i = 0; i < 2; i++) tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (fimPiscaLeds !== 1'b1) begin failures++; $display("FAIL hold_two_phases got=%b exp=1", fimPiscaLeds); end
    for (int i = 0; i < 2; i++) tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (fimLedsOn !== 1'b1) begin failures++; $display("FAIL hold_last_fimOn got=%b exp=1", fimLedsOn); end
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (db_estado !== 2'b00) begin failures++; $display("FAIL hold_end_estado got=%b exp=00", db_estado); end
    checks++; if (fimPiscaLeds !== 1'b0) begin failures++; $display("FAIL hold_end_fimPisca got=%b exp=0", fimPiscaLeds); end
    idle(1);
  endtask

  task automatic test_leds;
    acertos = 4'b1010;
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (leds !== 4'b1010) begin failures++; $display("FAIL leds_on got=%b exp=1010", leds); end
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    checks++; if (leds !== 4'b1010) begin failures++; $display("FAIL leds_off_first got=%b exp=1010", leds); end
    tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    checks++; if (leds !== 4'b0000) begin failures++; $display("FAIL leds_off_blank got=%b exp=0000", leds); end
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (leds !== 4'b0000) begin failures++; $display("FAIL leds_on_first got=%b exp=0000", leds); end
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (leds !== 4'b1010) begin failures++; $display("FAIL leds_on_resume got=%b exp=1010", leds); end
    acertos = 4'b0110;
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (leds !== 4'b0110) begin failures++; $display("FAIL leds_follow got=%b exp=0110", leds); end
    idle(2);
    acertos = 4'b1010;
  endtask

  task automatic test_saturate;
    logic [4:0] esperado;
    esperado = 5'b11100;
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      checks++; if (fimLedsOn !== esperado[i]) begin failures++; $display("FAIL sat_fimOn c%0d got=%b exp=%b", i, fimLedsOn, esperado[i]); end
    end
    idle(2);
  endtask

  task automatic test_simultaneous;
    logic [2:0] esperadoOn;
    esperadoOn = 3'b100;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      checks++; if (fimLedsOn !== esperadoOn[i]) begin failures++; $display("FAIL both_fimOn c%0d got=%b exp=%b", i, fimLedsOn, esperadoOn[i]); end
      checks++; if (fimLedsOff !== 1'b0) begin failures++; $display("FAIL both_fimOff c%0d got=%b exp=0", i, fimLedsOff); end
    end
    tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checks++; if (fimLedsOff !== 1'b0) begin failures++; $display("FAIL both_off_first got=%b exp=0", fimLedsOff); end
    tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checks++; if (fimLedsOff !== 1'b1) begin failures++; $display("FAIL both_off_last got=%b exp=1", fimLedsOff); end
    idle(2);
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 11; i++) tick(1'b0, ON_V[i], OFF_V[i], OFF_V[i], 1'b0);
    checks++; if (fimPiscaLeds !== 1'b1) begin failures++; $display("FAIL rmid_pre_fimPisca got=%b exp=1", fimPiscaLeds); end
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (db_estado !== 2'b00) begin failures++; $display("FAIL rmid_estado got=%b exp=00", db_estado); end
    checks++; if (leds !== 4'b0000) begin failures++; $display("FAIL rmid_leds got=%b exp=0000", leds); end
    checks++; if (fimPiscaLeds !== 1'b0) begin failures++; $display("FAIL rmid_fimPisca got=%b exp=0", fimPiscaLeds); end
    checks++; if (fimLedsOn !== 1'b0) begin failures++; $display("FAIL rmid_fimOn0 got=%b exp=0", fimLedsOn); end
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (db_estado !== 2'b01) begin failures++; $display("FAIL rmid_restart_estado got=%b exp=01", db_estado); end
    checks++; if (fimLedsOn !== 1'b0) begin failures++; $display("FAIL rmid_fimOn1 got=%b exp=0", fimLedsOn); end
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (fimLedsOn !== 1'b1) begin failures++; $display("FAIL rmid_fimOn2 got=%b exp=1", fimLedsOn); end
    idle(2);
  endtask

  task automatic test_abort;
    for (int i = 0; i < 6; i++) tick(1'b0, ON_V[i], OFF_V[i], OFF_V[i], 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (db_estado !== 2'b01) begin failures++; $display("FAIL abort_pre_estado got=%b exp=01", db_estado); end
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (db_estado !== 2'b00) begin failures++; $display("FAIL abort_estado got=%b exp=00", db_estado); end
    idle(1);
    for (int i = 0; i < 5; i++) tick(1'b0, ON_V[i], OFF_V[i], OFF_V[i], 1'b0);
    checks++; if (fimLedsOff !== 1'b1) begin failures++; $display("FAIL abort_new_fimOff got=%b exp=1", fimLedsOff); end
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (fimPiscaLeds !== 1'b0) begin failures++; $display("FAIL abort_new_fimPisca got=%b exp=0", fimPiscaLeds); end
    idle(2);
  endtask

`ifdef PISCA_CHECK_EN
  task automatic test_protocolo;
    checks++; if (erro_protocolo !== 1'b0) begin failures++; $display("FAIL prot_initial got=%b exp=0", erro_protocolo); end
    tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (erro_protocolo !== 1'b1) begin failures++; $display("FAIL prot_set got=%b exp=1", erro_protocolo); end
    idle(10);
    checks++; if (erro_protocolo !== 1'b1) begin failures++; $display("FAIL prot_sticky got=%b exp=1", erro_protocolo); end
  endtask
`endif

  initial begin
    test_reset;
`ifdef PISCA_CHECK_EN
    test_protocolo;
`endif
    test_burst;
    test_piscadas_hold;
    test_leds;
    test_saturate;
    test_simultaneous;
    test_reset_mid;
    test_abort;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
